// File: rtl/ats_pkg.sv
// -----------------------------------------------------------------------------
// ats_pkg
// Shared definitions for the Asynchronous Traffic Shaping blocks (per-stream
// scheduler, eligibility-time gate, future shaper arrays).
//   - Default widths for time values, frame lengths and per-byte recovery time.
//   - State encoding of the per-stream token-bucket scheduler FSM.
// -----------------------------------------------------------------------------
package ats_pkg;

   // Timer-unit timestamps, unsigned, modulo 2^width
   localparam int DEFAULT_TIMESTAMP_WIDTH     = 72;
   // Frame length in bytes
   localparam int DEFAULT_FRAME_LENGTH_WIDTH  = 16;
   // Bucket recovery time per byte (8/CIR in timer units)
   localparam int DEFAULT_TIME_PER_BYTE_WIDTH = 32;

   // One frame walks IDLE -> CALC_LENGTH -> CALC_ELIGIBILITY -> UPDATE -> OUTPUT
   typedef enum logic [2:0] {
      ATS_IDLE             = 3'd0,
      ATS_CALC_LENGTH      = 3'd1,
      ATS_CALC_ELIGIBILITY = 3'd2,
      ATS_UPDATE           = 3'd3,
      ATS_OUTPUT           = 3'd4
   } ats_state_e;

endpackage : ats_pkg

// File: rtl/ats_scheduler.sv
// -----------------------------------------------------------------------------
// ats_scheduler
// Per-stream ATS token-bucket shaper. For every frame it computes the
// eligibility timestamp from the committed rate, burst size, bucket empty time
// (BET) and group eligibility time (GET), and flags frames whose eligibility
// time lies beyond arrival + max residence time for discard.
//
// Ports:
//   clk, rstn                              clock, synchronous active-low reset
//   committed_time_per_byte                bucket recovery time per byte
//   empty_to_full_duration                 time for an empty bucket to fill
//   max_residence_time                     discard threshold relative to arrival
//   s_axis_frame_info_*                    frame arrival time / length input
//   m_axis_eligibility_timestamp_*         eligibility time out, tuser=discard
// -----------------------------------------------------------------------------
module ats_scheduler
   import ats_pkg::*;
#(
   parameter int TIMESTAMP_WIDTH     = DEFAULT_TIMESTAMP_WIDTH,
   parameter int FRAME_LENGTH_WIDTH  = DEFAULT_FRAME_LENGTH_WIDTH,
   parameter int TIME_PER_BYTE_WIDTH = DEFAULT_TIME_PER_BYTE_WIDTH
)(
   input  logic                           clk,
   input  logic                           rstn,

   input  logic [TIME_PER_BYTE_WIDTH-1:0] committed_time_per_byte,
   input  logic [TIMESTAMP_WIDTH-1:0]     empty_to_full_duration,
   input  logic [TIMESTAMP_WIDTH-1:0]     max_residence_time,

   input  logic [TIMESTAMP_WIDTH-1:0]     s_axis_frame_info_arrival_time,
   input  logic [FRAME_LENGTH_WIDTH-1:0]  s_axis_frame_info_length,
   input  logic                           s_axis_frame_info_tvalid,
   output logic                           s_axis_frame_info_tready,

   output logic [TIMESTAMP_WIDTH-1:0]     m_axis_eligibility_timestamp_tdata,
   output logic                           m_axis_eligibility_timestamp_tuser,
   output logic                           m_axis_eligibility_timestamp_tvalid,
   input  logic                           m_axis_eligibility_timestamp_tready
);

   localparam int PRODUCT_WIDTH = FRAME_LENGTH_WIDTH + TIME_PER_BYTE_WIDTH;

   ats_state_e state_q, state_d;

   // Frame and configuration captured at acceptance so that config changes
   // during processing do not affect the frame in flight
   logic [TIMESTAMP_WIDTH-1:0]     arrival_q, arrival_d;
   logic [FRAME_LENGTH_WIDTH-1:0]  length_q, length_d;
   logic [TIME_PER_BYTE_WIDTH-1:0] tpb_q, tpb_d;
   logic [TIMESTAMP_WIDTH-1:0]     etf_q, etf_d;
   logic [TIMESTAMP_WIDTH-1:0]     mrt_q, mrt_d;

   // Pipeline intermediates
   logic [TIMESTAMP_WIDTH-1:0]     lrd_q, lrd_d;
   logic [TIMESTAMP_WIDTH-1:0]     bft_q, bft_d;
   logic [TIMESTAMP_WIDTH-1:0]     set_q, set_d;
   logic [TIMESTAMP_WIDTH-1:0]     et_q, et_d;
   logic                           discard_q, discard_d;

   // Persistent shaper state
   logic [TIMESTAMP_WIDTH-1:0]     bet_q, bet_d;
   logic [TIMESTAMP_WIDTH-1:0]     get_q, get_d;

   // Combinational helpers
   logic [PRODUCT_WIDTH-1:0]       product;
   logic [TIMESTAMP_WIDTH-1:0]     set_sum;
   logic [TIMESTAMP_WIDTH-1:0]     et_max;
   logic [TIMESTAMP_WIDTH-1:0]     deadline;

   // Datapath helpers: length-rate product (never truncated before the
   // zero-extension to timestamp width), scheduled eligibility time, the
   // three-way maximum and the residence deadline. All modulo arithmetic.
   always_comb begin
      product  = PRODUCT_WIDTH'(length_q) * PRODUCT_WIDTH'(tpb_q);
      set_sum  = bet_q + lrd_q;
      et_max   = arrival_q;
      if (get_q > et_max) begin
         et_max = get_q;
      end
      if (set_sum > et_max) begin
         et_max = set_sum;
      end
      deadline = arrival_q + mrt_q;
   end

   // Next-state and datapath update. Every register holds by default; each
   // state only touches the values it is responsible for. BET/GET are only
   // committed when the frame is not discarded.
   always_comb begin
      state_d   = state_q;
      arrival_d = arrival_q;
      length_d  = length_q;
      tpb_d     = tpb_q;
      etf_d     = etf_q;
      mrt_d     = mrt_q;
      lrd_d     = lrd_q;
      bft_d     = bft_q;
      set_d     = set_q;
      et_d      = et_q;
      discard_d = discard_q;
      bet_d     = bet_q;
      get_d     = get_q;

      unique case (state_q)
         ATS_IDLE: begin
            if (s_axis_frame_info_tvalid) begin
               arrival_d = s_axis_frame_info_arrival_time;
               length_d  = s_axis_frame_info_length;
               tpb_d     = committed_time_per_byte;
               etf_d     = empty_to_full_duration;
               mrt_d     = max_residence_time;
               state_d   = ATS_CALC_LENGTH;
            end
         end
         ATS_CALC_LENGTH: begin
            lrd_d   = TIMESTAMP_WIDTH'(product);
            bft_d   = bet_q + etf_q;
            state_d = ATS_CALC_ELIGIBILITY;
         end
         ATS_CALC_ELIGIBILITY: begin
            set_d   = set_sum;
            et_d    = et_max;
            state_d = ATS_UPDATE;
         end
         ATS_UPDATE: begin
            if (et_q <= deadline) begin
               get_d     = et_q;
               // A frame later than the bucket-full time finds a full bucket;
               // the excess waiting time is added so tokens never exceed CBS
               bet_d     = (et_q < bft_q) ? set_q : (set_q + et_q - bft_q);
               discard_d = 1'b0;
            end else begin
               discard_d = 1'b1;
            end
            state_d = ATS_OUTPUT;
         end
         ATS_OUTPUT: begin
            if (m_axis_eligibility_timestamp_tready) begin
               state_d = ATS_IDLE;
            end
         end
         default: begin
            state_d = ATS_IDLE;
         end
      endcase
   end

   // State register. Reset drops any in-flight frame and clears BET/GET.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= ATS_IDLE;
         arrival_q <= '0;
         length_q  <= '0;
         tpb_q     <= '0;
         etf_q     <= '0;
         mrt_q     <= '0;
         lrd_q     <= '0;
         bft_q     <= '0;
         set_q     <= '0;
         et_q      <= '0;
         discard_q <= 1'b0;
         bet_q     <= '0;
         get_q     <= '0;
      end else begin
         state_q   <= state_d;
         arrival_q <= arrival_d;
         length_q  <= length_d;
         tpb_q     <= tpb_d;
         etf_q     <= etf_d;
         mrt_q     <= mrt_d;
         lrd_q     <= lrd_d;
         bft_q     <= bft_d;
         set_q     <= set_d;
         et_q      <= et_d;
         discard_q <= discard_d;
         bet_q     <= bet_d;
         get_q     <= get_d;
      end
   end

   // Handshake outputs decode straight from registered state so tdata/tuser
   // stay stable while the downstream gate back-pressures
   always_comb begin
      s_axis_frame_info_tready            = (state_q == ATS_IDLE);
      m_axis_eligibility_timestamp_tvalid = (state_q == ATS_OUTPUT);
      m_axis_eligibility_timestamp_tdata  = et_q;
      m_axis_eligibility_timestamp_tuser  = discard_q;
   end

endmodule : ats_scheduler
